// File: rtl/seg_scan_display.sv
// Multiplexed N-digit seven-segment driver with hex or decimal display,
// leading-zero blanking, decimal points and PWM brightness.
module seg_scan_display #(
  parameter int DIGITS    = 4,
  parameter int DIVIDE_BY = 100000,
  parameter int BRIGHT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  mode,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic                  busy,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n
);

  localparam int W  = 4 * DIGITS;
  localparam int BW = W + 4;
  localparam int SW = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
  localparam int DW = $clog2(DIGITS);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    HEX,
    CONV,
    COMMIT
  } stateT;

  stateT state, stateNext;

  logic [W-1:0]  binReg;
  logic [W-1:0]  resReg;
  logic [W-1:0]  dispReg;
  logic [BW-1:0] bcdReg;
  logic [BW-1:0] bcdAdj;
  logic [CW-1:0] stepCnt;
  logic          resOvf;
  logic          dispOvf;

  logic [SW-1:0]       slotCnt;
  logic [DW-1:0]       digitIdx;
  logic [BRIGHT_W-1:0] pwmCnt;

  logic [3:0]        nib;
  logic [W-1:0]      upper;
  logic              lzBlank;
  logic              anOn;
  logic [6:0]        glyph;
  logic [DIGITS-1:0] anNext;

  function automatic logic [6:0] hexGlyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    bcdAdj = bcdReg;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcdReg[4*i +: 4] >= 4'd5)
        bcdAdj[4*i +: 4] = bcdReg[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   stateNext = IDLE;
      HEX:    stateNext = COMMIT;
      CONV:   if (stepCnt == CW'(W)) stateNext = COMMIT;
      COMMIT: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (load) stateNext = mode ? CONV : HEX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // A fresh load always wins and suppresses any pending commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      binReg  <= '0;
      bcdReg  <= '0;
      stepCnt <= '0;
      resReg  <= '0;
      resOvf  <= 1'b0;
      dispReg <= '0;
      dispOvf <= 1'b0;
    end else if (load) begin
      binReg  <= value;
      bcdReg  <= '0;
      stepCnt <= '0;
      resOvf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        HEX: begin
          resReg <= binReg;
          resOvf <= 1'b0;
        end
        CONV: begin
          if (stepCnt != CW'(W)) begin
            {bcdReg, binReg} <= {bcdAdj[BW-2:0], binReg, 1'b0};
            resOvf  <= resOvf | bcdAdj[BW-1];
            stepCnt <= stepCnt + CW'(1);
          end else begin
            resReg <= bcdReg[W-1:0];
            resOvf <= resOvf | (|bcdReg[BW-1:W]);
          end
        end
        COMMIT: begin
          dispReg <= resReg;
          dispOvf <= resOvf;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nib     = dispReg[4*digitIdx +: 4];
    upper   = dispReg >> {digitIdx, 2'b00};
    lzBlank = blank_lz && (digitIdx != '0) && (upper == '0);
    if (dispOvf)      glyph = 7'h3F;
    else if (lzBlank) glyph = 7'h7F;
    else              glyph = hexGlyph(nib);
    anOn   = (&brightness) || (pwmCnt < brightness);
    anNext = ~(DIGITS'(anOn) << digitIdx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotCnt  <= '0;
      digitIdx <= '0;
      pwmCnt   <= '0;
      an       <= '1;
      seg      <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      pwmCnt <= pwmCnt + 1'b1;
      if (slotCnt == SW'(DIVIDE_BY - 1)) begin
        slotCnt <= '0;
        if (digitIdx == DW'(DIGITS - 1)) digitIdx <= '0;
        else                             digitIdx <= digitIdx + 1'b1;
      end else begin
        slotCnt <= slotCnt + 1'b1;
      end
      an   <= anNext;
      seg  <= glyph;
      dp_n <= ~dp[digitIdx];
    end
  end

endmodule
